// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and, later, the transmitter:
// FSM states, oversampling constants and the bit-decision vote.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] SAMPLE_TICK_0 = 4'd7;
    localparam logic [3:0] SAMPLE_TICK_1 = 4'd8;
    localparam logic [3:0] SAMPLE_TICK_2 = 4'd9;
    localparam logic [3:0] LAST_TICK     = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT      = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every CLKS_PER_TICK clocks,
// restartable with clr so a receiver can phase-align to a start edge.
module uart_baud_tick #(
    parameter int CLKS_PER_TICK = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority per bit, a single
// holding register with valid/ack handshake and sticky framing/overrun flags.
module uart_rx #(
    parameter int CLKS_PER_TICK = 27,
    parameter int OVERSAMPLE    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_ack,
    input  logic       status_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    import uart_pkg::*;

    if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_oversample_check
        $error("uart_rx: OVERSAMPLE must be 16");
    end

    rx_state_e  state_q, state_d;
    logic       rx_meta_q, rx_s_q, rx_prev_q;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] samp_q, samp_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    logic       tick;
    logic       start_edge;
    logic       bit_val;
    logic       at_vote;
    logic       at_last_tick;
    logic       div_clr;
    logic       shift_en;
    logic       deliver;
    logic       stop_bad;

    uart_baud_tick #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (div_clr),
        .tick (tick)
    );

    // rx is asynchronous; nothing downstream looks at it before rx_s_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign start_edge   = rx_prev_q && !rx_s_q;
    assign bit_val      = majority3(samp_q[1], samp_q[0], rx_s_q);
    assign at_vote      = tick && (tick_cnt_q == SAMPLE_TICK_2);
    assign at_last_tick = tick && (tick_cnt_q == LAST_TICK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_edge) state_d = START;
            end
            START: begin
                if (at_vote && bit_val) begin
                    state_d = IDLE;
                end else if (at_last_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_last_tick && (bit_cnt_q == LAST_BIT)) state_d = STOP;
            end
            STOP: begin
                if (at_vote) state_d = bit_val ? IDLE : BREAK;
            end
            BREAK: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_busy  = (state_q != IDLE);
        div_clr  = (state_q == IDLE) && start_edge;
        shift_en = (state_q == DATA) && at_vote;
        deliver  = (state_q == STOP) && at_vote && bit_val;
        stop_bad = (state_q == STOP) && at_vote && !bit_val;
    end

    // Tick and bit positions restart on every start edge so each frame is phase-aligned.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (div_clr) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            if ((state_q == DATA) && (tick_cnt_q == LAST_TICK)) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    always_comb begin
        samp_d  = samp_q;
        shift_d = shift_q;
        if (tick && (tick_cnt_q == SAMPLE_TICK_0)) samp_d[1] = rx_s_q;
        if (tick && (tick_cnt_q == SAMPLE_TICK_1)) samp_d[0] = rx_s_q;
        if (shift_en) shift_d = {bit_val, shift_q[7:1]};
    end

    // NOTE: sample and shift registers carry no reset; every frame overwrites them before they are read.
    always_ff @(posedge clk) begin
        samp_q  <= samp_d;
        shift_q <= shift_d;
    end

    // An ack in the delivery cycle frees the holding register for the new byte.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (rx_ack) rx_valid_d = 1'b0;
        if (deliver && (!rx_valid_q || rx_ack)) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
        end
        if (status_clr) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (stop_bad) frame_err_d = 1'b1;
        if (deliver && rx_valid_q && !rx_ack) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are built from the 8N1 rules,
// expected bytes go into a scoreboard queue and a monitor compares deliveries.
module tb_uart_rx;

    localparam int CPT      = 4;
    localparam int BIT_CLKS = 16 * CPT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       dir_ack = 1'b0;
    logic       mon_ack = 1'b0;
    logic       status_clr = 1'b0;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    bit         auto_ack = 1'b0;
    int         lat;

    assign rx_ack = dir_ack | mon_ack;

    uart_rx #(
        .CLKS_PER_TICK(CPT),
        .OVERSAMPLE   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_ack    (rx_ack),
        .status_clr(status_clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame, LSB first; noise_bit >= 0 inverts one tick's worth of that data bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int noise_bit);
        rx = 1'b0;
        idle(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            if (i == noise_bit) begin
                idle(30);
                rx = ~data[i];
                idle(CPT);
                rx = data[i];
                idle(BIT_CLKS - 30 - CPT);
            end else begin
                idle(BIT_CLKS);
            end
        end
        rx = stop_bit;
        idle(BIT_CLKS);
    endtask

    task automatic pulse_clr();
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_data"}, rx_data, 8'h00);
        check({tag, "_rx_valid"}, rx_valid, 1'b0);
        check({tag, "_rx_busy"}, rx_busy, 1'b0);
        check({tag, "_frame_err"}, frame_err, 1'b0);
        check({tag, "_overrun"}, overrun, 1'b0);
    endtask

    // Scoreboard monitor: every delivered byte is acked and matched in order.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack && rx_valid && !mon_ack) begin
                check("sb_byte_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("sb_rx_data", rx_data, exp_q.pop_front());
                mon_ack = 1'b1;
            end else begin
                mon_ack = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [7:0] d;
        int gap;
        int noise;

        idle(3);
        rst_n = 1'b1;
        idle(2);
        check_idle_outputs("reset");

        // Single byte with latency bound and held-until-ack behaviour.
        auto_ack = 1'b0;
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, -1);
            begin
                while (!rx_valid && lat < 700) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("a5_latency_le_620", 32'(lat <= 620), 1);
        check("a5_rx_data", rx_data, 8'hA5);
        check("a5_rx_valid", rx_valid, 1'b1);
        check("a5_frame_err", frame_err, 1'b0);
        check("a5_overrun", overrun, 1'b0);
        idle(20);
        check("a5_valid_held", rx_valid, 1'b1);
        dir_ack = 1'b1;
        @(negedge clk);
        dir_ack = 1'b0;
        check("a5_valid_after_ack", rx_valid, 1'b0);

        // Back-to-back frames with no idle gap.
        auto_ack = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        idle(40);
        check("b2b_queue_drained", exp_q.size(), 0);
        check("b2b_frame_err", frame_err, 1'b0);
        check("b2b_overrun", overrun, 1'b0);

        // 20-clk low glitch is a false start.
        rx = 1'b0;
        idle(10);
        check("glitch_busy_set", rx_busy, 1'b1);
        idle(10);
        rx = 1'b1;
        cnt = 20;
        while (rx_busy && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("glitch_busy_cleared", rx_busy, 1'b0);
        idle(100);
        check("glitch_no_valid", rx_valid, 1'b0);
        check("glitch_frame_err", frame_err, 1'b0);

        // Single-tick noise inside a data bit is outvoted.
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 2);
        idle(40);
        check("noise_queue_drained", exp_q.size(), 0);

        // Framing error followed by a held-low line.
        send_frame(8'h55, 1'b0, -1);
        idle(200);
        check("ferr_set", frame_err, 1'b1);
        check("ferr_no_valid", rx_valid, 1'b0);
        check("ferr_break_busy", rx_busy, 1'b1);
        rx = 1'b1;
        idle(10);
        check("ferr_break_released", rx_busy, 1'b0);
        check("ferr_sticky", frame_err, 1'b1);
        pulse_clr();
        check("ferr_cleared", frame_err, 1'b0);
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, -1);
        idle(40);
        check("ferr_recovery_drained", exp_q.size(), 0);

        // Overrun: second byte arrives while the first is unread.
        auto_ack = 1'b0;
        idle(4);
        send_frame(8'h11, 1'b1, -1);
        idle(10);
        check("ovr_first_valid", rx_valid, 1'b1);
        check("ovr_first_data", rx_data, 8'h11);
        send_frame(8'h22, 1'b1, -1);
        idle(10);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_flag_set", overrun, 1'b1);
        check("ovr_valid_kept", rx_valid, 1'b1);
        pulse_clr();
        check("ovr_flag_cleared", overrun, 1'b0);

        // Ack landing in the delivery cycle: new byte taken, no overrun.
        fork
            send_frame(8'h22, 1'b1, -1);
            begin
                idle(lat - 1);
                dir_ack = 1'b1;
                @(negedge clk);
                dir_ack = 1'b0;
            end
        join
        idle(5);
        check("ackdel_data", rx_data, 8'h22);
        check("ackdel_valid", rx_valid, 1'b1);
        check("ackdel_no_overrun", overrun, 1'b0);

        // Reset during data bit 4 of 0xC3; the sender abandons the frame.
        rx = 1'b0;
        idle(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            d = 8'hC3;
            rx = d[i];
            idle(BIT_CLKS);
        end
        rx = 1'b0;
        idle(BIT_CLKS / 2);
        check("rst_mid_busy_before", rx_busy, 1'b1);
        rst_n = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs("rst_mid");
        auto_ack = 1'b1;
        idle(BIT_CLKS);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, -1);
        idle(40);
        check("rst_mid_7e_drained", exp_q.size(), 0);

        // Randomised frames, gaps and single-tick noise.
        for (int f = 0; f < 16; f++) begin
            d = 8'($urandom);
            gap = int'($urandom_range(80, 0));
            noise = ($urandom_range(2, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
            exp_q.push_back(d);
            send_frame(d, 1'b1, noise);
            idle(gap);
        end
        idle(80);
        check("rand_queue_drained", exp_q.size(), 0);
        check("rand_frame_err", frame_err, 1'b0);
        check("rand_overrun", overrun, 1'b0);
        check("rand_idle", rx_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
